// File: rtl/qvalue_update.sv
// Q-value update stage: scans the neighbour table for the best next hop, then
// computes newQ = (1-a)*oldQ + a*(reward + g*bestQ). Optional macro QUPDATE_CLAMP_EN.
module qvalue_update #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned FRAC_BITS      = 12,
  parameter int unsigned NEIGHBOR_COUNT = 8,
  localparam int unsigned ID_W          = $clog2(NEIGHBOR_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  nbr_wr_en,
  input  logic [ID_W-1:0]       nbr_id,
  input  logic [WORD_WIDTH-1:0] nbr_qvalue,
  input  logic                  nbr_clr,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] old_qvalue,
  input  logic [WORD_WIDTH-1:0] reward,
  input  logic [WORD_WIDTH-1:0] alpha,
  input  logic [WORD_WIDTH-1:0] gamma,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] new_qvalue,
  output logic [ID_W-1:0]       best_hop_id,
  output logic                  best_hop_valid
);

  localparam int unsigned PW = 2 * WORD_WIDTH;
  localparam int unsigned UW = 2 * WORD_WIDTH + 1;
  localparam logic [WORD_WIDTH-1:0] ONE  = WORD_WIDTH'(1 << FRAC_BITS);
  localparam logic [WORD_WIDTH-1:0] MAXW = '1;
`ifdef QUPDATE_CLAMP_EN
  localparam logic [WORD_WIDTH-1:0] SAT  = ONE;
`else
  localparam logic [WORD_WIDTH-1:0] SAT  = MAXW;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_TARGET, S_UPDATE, S_DONE} state_t;

  state_t state, next_state;

  logic [WORD_WIDTH-1:0] tbl_q [NEIGHBOR_COUNT];
  logic [NEIGHBOR_COUNT-1:0] tbl_vld;

  logic [ID_W-1:0]       idx;
  logic [WORD_WIDTH-1:0] best_q;
  logic [ID_W-1:0]       best_id;
  logic                  found;
  logic [WORD_WIDTH-1:0] old_q, reward_q, alpha_q, gamma_q, target_q;

  logic                  last_c;
  logic                  hit_c;
  logic [PW-1:0]         prod_c;
  logic [PW:0]           tsum_c;
  logic [WORD_WIDTH-1:0] target_c;
  logic [WORD_WIDTH-1:0] one_m_c;
  logic [UW-1:0]         usum_c;
  logic [UW-1:0]         ush_c;
  logic [WORD_WIDTH-1:0] newq_c;

  // Neighbour table; a clear and a write in the same cycle leave the written entry valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEIGHBOR_COUNT; i++) tbl_q[i] <= '0;
      tbl_vld <= '0;
    end else begin
      if (nbr_clr) tbl_vld <= '0;
      if (nbr_wr_en) begin
        tbl_q[nbr_id]   <= nbr_qvalue;
        tbl_vld[nbr_id] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  assign last_c = (idx == ID_W'(NEIGHBOR_COUNT - 1));

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_SCAN;
      S_SCAN:   if (last_c) next_state = S_TARGET;
      S_TARGET: next_state = S_UPDATE;
      S_UPDATE: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Strict compare keeps the lowest index on ties
  always_comb begin
    hit_c = tbl_vld[idx] && (!found || (tbl_q[idx] > best_q));

    prod_c   = PW'(gamma_q) * PW'(best_q);
    tsum_c   = (PW + 1)'(reward_q) + (PW + 1)'(prod_c >> FRAC_BITS);
    target_c = (tsum_c > (PW + 1)'(MAXW)) ? MAXW : tsum_c[WORD_WIDTH-1:0];

    one_m_c = ONE - alpha_q;
    usum_c  = UW'(one_m_c) * UW'(old_q) + UW'(alpha_q) * UW'(target_q);
    ush_c   = usum_c >> FRAC_BITS;
    newq_c  = (ush_c > UW'(SAT)) ? SAT : ush_c[WORD_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      new_qvalue     <= '0;
      best_hop_id    <= '0;
      best_hop_valid <= 1'b0;
      idx            <= '0;
      best_q         <= '0;
      best_id        <= '0;
      found          <= 1'b0;
      old_q          <= '0;
      reward_q       <= '0;
      alpha_q        <= '0;
      gamma_q        <= '0;
      target_q       <= '0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            old_q    <= old_qvalue;
            reward_q <= reward;
            alpha_q  <= (alpha > ONE) ? ONE : alpha;
            gamma_q  <= gamma;
            idx      <= '0;
            best_q   <= '0;
            best_id  <= '0;
            found    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (hit_c) begin
            best_q  <= tbl_q[idx];
            best_id <= idx;
            found   <= 1'b1;
          end
          idx <= idx + ID_W'(1);
        end
        S_TARGET: target_q <= target_c;
        S_UPDATE: begin
          new_qvalue     <= newq_c;
          best_hop_id    <= best_id;
          best_hop_valid <= found;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qvalue_update.sv
// Directed self-checking bench for qvalue_update (default or QUPDATE_CLAMP_EN build).
module tb_qvalue_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        nbr_wr_en;
  logic [2:0]  nbr_id;
  logic [15:0] nbr_qvalue;
  logic        nbr_clr;
  logic        start;
  logic [15:0] old_qvalue, reward, alpha, gamma;
  logic        busy, done;
  logic [15:0] new_qvalue;
  logic [2:0]  best_hop_id;
  logic        best_hop_valid;

  int checks = 0;
  int failures = 0;

  qvalue_update dut (
    .clk(clk), .rst(rst), .nbr_wr_en(nbr_wr_en), .nbr_id(nbr_id),
    .nbr_qvalue(nbr_qvalue), .nbr_clr(nbr_clr), .start(start),
    .old_qvalue(old_qvalue), .reward(reward), .alpha(alpha), .gamma(gamma),
    .busy(busy), .done(done), .new_qvalue(new_qvalue),
    .best_hop_id(best_hop_id), .best_hop_valid(best_hop_valid)
  );

  always #5 clk = ~clk;

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_nbr(input logic [2:0] id, input logic [15:0] val);
    nbr_wr_en = 1'b1; nbr_id = id; nbr_qvalue = val;
    wait_cycle();
    nbr_wr_en = 1'b0;
  endtask

  task automatic clear_tbl();
    nbr_clr = 1'b1;
    wait_cycle();
    nbr_clr = 1'b0;
  endtask

  task automatic set_ops(input logic [15:0] o, input logic [15:0] r,
                         input logic [15:0] a, input logic [15:0] g);
    old_qvalue = o; reward = r; alpha = a; gamma = g;
  endtask

  // Starts one update from IDLE; lat = cycle index of done (1 = cycle after start), -1 if none
  task automatic run_op(input logic [15:0] o, input logic [15:0] r,
                        input logic [15:0] a, input logic [15:0] g, output int lat);
    set_ops(o, r, a, g);
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin lat = k; break; end
      wait_cycle();
    end
    wait_cycle();
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (new_qvalue !== 16'h0) begin failures++; $display("FAIL reset_newq got=%h exp=0000", new_qvalue); end
    checks++; if (best_hop_id !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", best_hop_id); end
    checks++; if (best_hop_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", best_hop_valid); end
  endtask

  task automatic test_nominal();
    int lat;
    clear_tbl();
    write_nbr(3'd2, 16'h0800);
    write_nbr(3'd5, 16'h0C00);
    run_op(16'h0800, 16'h0200, 16'h0800, 16'h0E66, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL nominal_latency got=%0d exp=11", lat); end
    checks++; if (new_qvalue !== 16'h0A66) begin failures++; $display("FAIL nominal_newq got=%h exp=0a66", new_qvalue); end
    checks++; if (best_hop_id !== 3'd5) begin failures++; $display("FAIL nominal_id got=%0d exp=5", best_hop_id); end
    checks++; if (best_hop_valid !== 1'b1) begin failures++; $display("FAIL nominal_valid got=%b exp=1", best_hop_valid); end
  endtask

  task automatic test_empty();
    int lat;
    clear_tbl();
    run_op(16'h1000, 16'h0000, 16'h1000, 16'h0E66, lat);
    checks++; if (new_qvalue !== 16'h0000) begin failures++; $display("FAIL empty_newq got=%h exp=0000", new_qvalue); end
    checks++; if (best_hop_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", best_hop_valid); end
    checks++; if (best_hop_id !== 3'd0) begin failures++; $display("FAIL empty_id got=%0d exp=0", best_hop_id); end
  endtask

  task automatic test_tie();
    int lat;
    clear_tbl();
    write_nbr(3'd6, 16'h0900);
    write_nbr(3'd1, 16'h0900);
    run_op(16'h0000, 16'h0000, 16'h1000, 16'h1000, lat);
    checks++; if (best_hop_id !== 3'd1) begin failures++; $display("FAIL tie_id got=%0d exp=1", best_hop_id); end
    checks++; if (new_qvalue !== 16'h0900) begin failures++; $display("FAIL tie_newq got=%h exp=0900", new_qvalue); end
  endtask

  // Entries 1 and 6 from the tie test stay loaded; clear+write must leave only entry 4
  task automatic test_clr_and_write();
    int lat;
    nbr_clr = 1'b1;
    write_nbr(3'd4, 16'h0500);
    nbr_clr = 1'b0;
    run_op(16'h0000, 16'h0000, 16'h1000, 16'h1000, lat);
    checks++; if (best_hop_id !== 3'd4) begin failures++; $display("FAIL clrwr_id got=%0d exp=4", best_hop_id); end
    checks++; if (new_qvalue !== 16'h0500) begin failures++; $display("FAIL clrwr_newq got=%h exp=0500", new_qvalue); end
  endtask

  task automatic test_alpha_clamp();
    int lat;
    clear_tbl();
    write_nbr(3'd3, 16'h0400);
    run_op(16'hFFFF, 16'h0100, 16'h2000, 16'h0800, lat);
    checks++; if (new_qvalue !== 16'h0300) begin failures++; $display("FAIL alpha_clamp_newq got=%h exp=0300", new_qvalue); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] exp_q;
`ifdef QUPDATE_CLAMP_EN
    exp_q = 16'h1000;
`else
    exp_q = 16'hFFFF;
`endif
    clear_tbl();
    write_nbr(3'd0, 16'h1000);
    run_op(16'h0000, 16'hF000, 16'h1000, 16'h1000, lat);
    checks++; if (new_qvalue !== exp_q) begin failures++; $display("FAIL sat_newq got=%h exp=%h", new_qvalue, exp_q); end
  endtask

  task automatic test_start_ignored();
    int ndone, lat;
    clear_tbl();
    write_nbr(3'd2, 16'h0800);
    write_nbr(3'd5, 16'h0C00);
    set_ops(16'h0800, 16'h0200, 16'h0800, 16'h0E66);
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 1; k <= 25; k++) begin
      if (done) begin ndone++; if (lat < 0) lat = k; end
      if (k == 4) begin start = 1'b1; set_ops(16'h0000, 16'hF000, 16'h1000, 16'h1000); end
      if (k == 5) start = 1'b0;
      wait_cycle();
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL ignore_latency got=%0d exp=11", lat); end
    checks++; if (new_qvalue !== 16'h0A66) begin failures++; $display("FAIL ignore_newq got=%h exp=0a66", new_qvalue); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16'h0800, 16'h0200, 16'h0800, 16'h0E66, lat);
    set_ops(16'h0800, 16'h0200, 16'h0800, 16'h0E66);
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 15; k++) begin
      wait_cycle();
      if (done) begin
        set_ops(16'h0000, 16'h0000, 16'h1000, 16'h1000);
        wait_cycle();
        wait_cycle();
        start = 1'b0;
        lat = 0;
        break;
      end
    end
    if (lat == 0) begin
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        if (done) begin lat = k; break; end
        wait_cycle();
      end
    end
    start = 1'b0;
    checks++; if (lat !== 11) begin failures++; $display("FAIL b2b_latency got=%0d exp=11", lat); end
    checks++; if (new_qvalue !== 16'h0C00) begin failures++; $display("FAIL b2b_newq got=%h exp=0c00", new_qvalue); end
    wait_cycle();
  endtask

  task automatic test_reset_mid_scan();
    int ndone, lat;
    write_nbr(3'd2, 16'h0800);
    set_ops(16'h0800, 16'h0200, 16'h0800, 16'h0E66);
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    wait_cycle();
    wait_cycle();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    wait_cycle();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      wait_cycle();
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    run_op(16'h0400, 16'h0100, 16'h0800, 16'h1000, lat);
    checks++; if (best_hop_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", best_hop_valid); end
    checks++; if (new_qvalue !== 16'h0280) begin failures++; $display("FAIL midrst_newq got=%h exp=0280", new_qvalue); end
  endtask

  initial begin
    rst = 1'b1; nbr_wr_en = 1'b0; nbr_id = '0; nbr_qvalue = '0; nbr_clr = 1'b0;
    start = 1'b0; old_qvalue = '0; reward = '0; alpha = '0; gamma = '0;
    wait_cycle();
    wait_cycle();
    test_reset();
    rst = 1'b0;
    wait_cycle();
    test_nominal();
    test_empty();
    test_tie();
    test_clr_and_write();
    test_alpha_clamp();
    test_saturation();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
